// File: rtl/fpu_pkg.sv
// Shared FPU memory-side constants and types, common to the arbiter and the FPU controller.
package fpu_pkg;

  localparam int unsigned BEAT_BYTES       = 32'd64;
  localparam int unsigned BURST_BEATS      = 32'd8;
  localparam int unsigned MEM_BUFFER_WIDTH = BEAT_BYTES * BURST_BEATS;
  localparam int unsigned BEAT_IDX_W       = $clog2(BURST_BEATS);

  typedef logic [BEAT_IDX_W-1:0] beat_idx_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_RD   = 2'd1,
    ARB_WR   = 2'd2,
    ARB_CFG  = 2'd3
  } arb_state_e;

  typedef enum logic {
    GRANT_RD = 1'b0,
    GRANT_WR = 1'b1
  } grant_e;

  function automatic logic [31:0] beat_addr(input logic [31:0] base, input beat_idx_t idx);
    return base + (32'(idx) * BEAT_BYTES);
  endfunction

endpackage

// File: rtl/fpu_mem_arbiter_if.sv
// Request/memory/buffer signals between the FPU controller, the arbiter and the memory port.
interface fpu_mem_arbiter_if;
  import fpu_pkg::*;

  logic        request_read;
  logic [31:0] read_address;
  logic        request_write;
  logic [31:0] write_address;
  logic        cfg_req;
  logic [31:0] cfg_addr;
  logic        mem_ack;
  logic        making_request;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic        rd_buf_we;
  logic        wr_buf_re;
  beat_idx_t   beat_idx;
  logic        cfg_valid;
  logic        req_overflow;

  modport master (
    input  request_read, read_address, request_write, write_address,
           cfg_req, cfg_addr, mem_ack,
    output making_request, mem_req, mem_we, mem_addr, rd_buf_we,
           wr_buf_re, beat_idx, cfg_valid, req_overflow
  );

  modport slave (
    output request_read, read_address, request_write, write_address,
           cfg_req, cfg_addr, mem_ack,
    input  making_request, mem_req, mem_we, mem_addr, rd_buf_we,
           wr_buf_re, beat_idx, cfg_valid, req_overflow
  );

endinterface

// File: rtl/fpu_req_latch.sv
// Turns a request pulse into a pending bit with a captured address; a pulse that arrives
// while the same request is pending or being served is dropped and flagged as overflow.
module fpu_req_latch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic        active_i,
  input  logic        clr_i,
  output logic        pending_o,
  output logic [31:0] addr_o,
  output logic        overflow_o
);

  logic        pending_q, pending_d;
  logic [31:0] addr_q, addr_d;
  logic        overflow_q, overflow_d;

  always_comb begin
    pending_d  = pending_q;
    addr_d     = addr_q;
    overflow_d = overflow_q;
    if (clr_i) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    // Address stays frozen while pending or active so the burst base cannot move under it.
    if (req_i && !pending_q && !active_i) begin
      pending_d = 1'b1;
      addr_d    = addr_i;
    end else if (req_i) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= 1'b0;
      addr_q     <= 32'h0000_0000;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      addr_q     <= addr_d;
      overflow_q <= overflow_d;
    end
  end

  assign pending_o  = pending_q;
  assign addr_o     = addr_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/fpu_mem_arbiter.sv
// Arbitrates read-buffer fill, write-buffer drain and config accesses onto the single memory
// port, issuing fixed BURST_BEATS-beat bursts for the buffers and single beats for config.
module fpu_mem_arbiter
  import fpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  fpu_mem_arbiter_if.master bus
);

  localparam beat_idx_t LAST_BEAT = beat_idx_t'(BURST_BEATS - 32'd1);

  arb_state_e  state_q, state_d;
  beat_idx_t   beat_q, beat_d;
  grant_e      last_grant_q, last_grant_d;

  logic        rd_pend_s, wr_pend_s, cfg_pend_s;
  logic        rd_clr_s, wr_clr_s, cfg_clr_s;
  logic [31:0] rd_base_s, wr_base_s, cfg_base_s;
  logic        rd_ovf_s, wr_ovf_s, cfg_ovf_s;

  fpu_req_latch u_rd_latch (
    .clk(clk), .rst_n(rst_n), .req_i(bus.request_read), .addr_i(bus.read_address),
    .active_i(state_q == ARB_RD), .clr_i(rd_clr_s),
    .pending_o(rd_pend_s), .addr_o(rd_base_s), .overflow_o(rd_ovf_s)
  );

  fpu_req_latch u_wr_latch (
    .clk(clk), .rst_n(rst_n), .req_i(bus.request_write), .addr_i(bus.write_address),
    .active_i(state_q == ARB_WR), .clr_i(wr_clr_s),
    .pending_o(wr_pend_s), .addr_o(wr_base_s), .overflow_o(wr_ovf_s)
  );

  fpu_req_latch u_cfg_latch (
    .clk(clk), .rst_n(rst_n), .req_i(bus.cfg_req), .addr_i(bus.cfg_addr),
    .active_i(state_q == ARB_CFG), .clr_i(cfg_clr_s),
    .pending_o(cfg_pend_s), .addr_o(cfg_base_s), .overflow_o(cfg_ovf_s)
  );

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    last_grant_d = last_grant_q;
    rd_clr_s     = 1'b0;
    wr_clr_s     = 1'b0;
    cfg_clr_s    = 1'b0;
    case (state_q)
      // Grants happen only from IDLE, so an active burst is never preempted.
      ARB_IDLE: begin
        beat_d = beat_idx_t'(0);
        if (cfg_pend_s) begin
          state_d   = ARB_CFG;
          cfg_clr_s = 1'b1;
        end else if (rd_pend_s && (!wr_pend_s || last_grant_q == GRANT_WR)) begin
          state_d      = ARB_RD;
          rd_clr_s     = 1'b1;
          last_grant_d = GRANT_RD;
        end else if (wr_pend_s) begin
          state_d      = ARB_WR;
          wr_clr_s     = 1'b1;
          last_grant_d = GRANT_WR;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_RD, ARB_WR: begin
        if (bus.mem_ack && beat_q == LAST_BEAT) begin
          state_d = ARB_IDLE;
          beat_d  = beat_idx_t'(0);
        end else if (bus.mem_ack) begin
          beat_d = beat_q + beat_idx_t'(1);
        end else begin
          beat_d = beat_q;
        end
      end
      ARB_CFG: begin
        if (bus.mem_ack) begin
          state_d = ARB_IDLE;
        end else begin
          state_d = ARB_CFG;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        beat_d  = beat_idx_t'(0);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      beat_q       <= beat_idx_t'(0);
      last_grant_q <= GRANT_WR;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    bus.mem_addr = 32'h0000_0000;
    case (state_q)
      ARB_RD:  bus.mem_addr = beat_addr(rd_base_s, beat_q);
      ARB_WR:  bus.mem_addr = beat_addr(wr_base_s, beat_q);
      ARB_CFG: bus.mem_addr = cfg_base_s;
      default: bus.mem_addr = 32'h0000_0000;
    endcase
  end

  assign bus.mem_req        = (state_q != ARB_IDLE);
  assign bus.mem_we         = (state_q == ARB_WR);
  assign bus.rd_buf_we      = (state_q == ARB_RD) && bus.mem_ack;
  assign bus.wr_buf_re      = (state_q == ARB_WR);
  assign bus.beat_idx       = beat_q;
  assign bus.cfg_valid      = (state_q == ARB_CFG) && bus.mem_ack;
  assign bus.making_request = rd_pend_s | wr_pend_s | cfg_pend_s | (state_q != ARB_IDLE);
  assign bus.req_overflow   = rd_ovf_s | wr_ovf_s | cfg_ovf_s;

endmodule

// File: tb/tb_fpu_mem_arbiter.sv
// Directed bench for fpu_mem_arbiter: inputs change and outputs are sampled just after the
// falling clock edge; expected values are hand-derived constants and beat address arithmetic.
module tb_fpu_mem_arbiter;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;

  fpu_mem_arbiter_if bus();

  fpu_mem_arbiter dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_req"},  32'(bus.mem_req),   32'd0);
    chk({tag, "_we"},   32'(bus.mem_we),    32'd0);
    chk({tag, "_addr"}, bus.mem_addr,       32'h0000_0000);
    chk({tag, "_rdwe"}, 32'(bus.rd_buf_we), 32'd0);
    chk({tag, "_wrre"}, 32'(bus.wr_buf_re), 32'd0);
    chk({tag, "_idx"},  32'(bus.beat_idx),  32'd0);
    chk({tag, "_cfgv"}, 32'(bus.cfg_valid), 32'd0);
  endtask

  // Checks beats first..last of a burst with mem_ack held high, advancing one cycle per beat.
  task automatic check_burst(input logic we, input logic [31:0] base, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      chk("burst_req",  32'(bus.mem_req),   32'd1);
      chk("burst_we",   32'(bus.mem_we),    32'(we));
      chk("burst_addr", bus.mem_addr,       base + 32'(i) * 32'd64);
      chk("burst_idx",  32'(bus.beat_idx),  32'(i));
      chk("burst_rdwe", 32'(bus.rd_buf_we), 32'(!we));
      chk("burst_wrre", 32'(bus.wr_buf_re), 32'(we));
      chk("burst_mkrq", 32'(bus.making_request), 32'd1);
      nxt();
    end
  endtask

  task automatic both_pulse(input logic [31:0] ra, input logic [31:0] wa);
    bus.request_read  = 1'b1;
    bus.read_address  = ra;
    bus.request_write = 1'b1;
    bus.write_address = wa;
    nxt();
    bus.request_read  = 1'b0;
    bus.request_write = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    bus.request_read  = 1'b0;
    bus.read_address  = 32'h0000_0000;
    bus.request_write = 1'b0;
    bus.write_address = 32'h0000_0000;
    bus.cfg_req       = 1'b0;
    bus.cfg_addr      = 32'h0000_0000;
    bus.mem_ack       = 1'b0;

    nxt();
    nxt();
    check_quiet("rst");
    chk("rst_mkrq", 32'(bus.making_request), 32'd0);
    chk("rst_ovf",  32'(bus.req_overflow),   32'd0);
    rst_n = 1'b1;
    nxt();
    check_quiet("post_rst");

    // Simultaneous RD+WR: RD first (last_grant resets to WR), one IDLE cycle, then WR.
    bus.mem_ack = 1'b1;
    both_pulse(32'h2000_0000, 32'h3000_0400);
    chk("rr1_mkrq", 32'(bus.making_request), 32'd1);
    chk("rr1_lat",  32'(bus.mem_req),        32'd0);
    nxt();
    check_burst(1'b0, 32'h2000_0000, 0, 7);
    chk("rr1_gap_req",  32'(bus.mem_req),        32'd0);
    chk("rr1_gap_mkrq", 32'(bus.making_request), 32'd1);
    nxt();
    check_burst(1'b1, 32'h3000_0400, 0, 7);
    check_quiet("rr1_end");
    chk("rr1_end_mkrq", 32'(bus.making_request), 32'd0);

    both_pulse(32'h2100_0000, 32'h3100_0000);
    nxt();
    check_burst(1'b0, 32'h2100_0000, 0, 7);
    chk("rr2_gap_req", 32'(bus.mem_req), 32'd0);
    nxt();
    check_burst(1'b1, 32'h3100_0000, 0, 7);
    check_quiet("rr2_end");

    // Single read burst with ack every cycle.
    bus.request_read = 1'b1;
    bus.read_address = 32'h1000_0200;
    nxt();
    bus.request_read = 1'b0;
    chk("rd_mkrq", 32'(bus.making_request), 32'd1);
    chk("rd_lat",  32'(bus.mem_req),        32'd0);
    nxt();
    chk("rd_first_addr", bus.mem_addr, 32'h1000_0200);
    check_burst(1'b0, 32'h1000_0200, 0, 7);
    check_quiet("rd_end");
    chk("rd_end_mkrq", 32'(bus.making_request), 32'd0);

    // cfg and WR arrive during a RD burst; cfg wins the next IDLE over the pending WR.
    bus.request_read = 1'b1;
    bus.read_address = 32'h4000_0000;
    nxt();
    bus.request_read = 1'b0;
    nxt();
    bus.cfg_req       = 1'b1;
    bus.cfg_addr      = 32'h1000_0120;
    bus.request_write = 1'b1;
    bus.write_address = 32'h5000_0000;
    check_burst(1'b0, 32'h4000_0000, 0, 0);
    bus.cfg_req       = 1'b0;
    bus.request_write = 1'b0;
    check_burst(1'b0, 32'h4000_0000, 1, 7);
    chk("cfg_gap_req",  32'(bus.mem_req),        32'd0);
    chk("cfg_gap_mkrq", 32'(bus.making_request), 32'd1);
    nxt();
    chk("cfg_req",   32'(bus.mem_req),   32'd1);
    chk("cfg_we",    32'(bus.mem_we),    32'd0);
    chk("cfg_addr",  bus.mem_addr,       32'h1000_0120);
    chk("cfg_valid", 32'(bus.cfg_valid), 32'd1);
    chk("cfg_rdwe",  32'(bus.rd_buf_we), 32'd0);
    nxt();
    check_quiet("cfg_gap2");
    chk("cfg_gap2_mkrq", 32'(bus.making_request), 32'd1);
    nxt();
    check_burst(1'b1, 32'h5000_0000, 0, 7);
    check_quiet("cfg_end");
    chk("cfg_ovf", 32'(bus.req_overflow), 32'd0);

    // Second write pulse during an active WR burst is dropped and sets sticky overflow.
    bus.request_write = 1'b1;
    bus.write_address = 32'h6000_0000;
    nxt();
    bus.request_write = 1'b0;
    nxt();
    bus.request_write = 1'b1;
    bus.write_address = 32'h7000_0000;
    check_burst(1'b1, 32'h6000_0000, 0, 0);
    bus.request_write = 1'b0;
    chk("ovf_set", 32'(bus.req_overflow), 32'd1);
    check_burst(1'b1, 32'h6000_0000, 1, 7);
    check_quiet("ovf_end");
    chk("ovf_end_mkrq", 32'(bus.making_request), 32'd0);
    nxt();
    chk("ovf_no_second", 32'(bus.mem_req),      32'd0);
    chk("ovf_sticky",    32'(bus.req_overflow), 32'd1);

    // Address wrap at 2^32 and a five-cycle ack stall on beat 3.
    bus.request_read = 1'b1;
    bus.read_address = 32'hFFFF_FFC0;
    nxt();
    bus.request_read = 1'b0;
    nxt();
    chk("wrap_b0", bus.mem_addr, 32'hFFFF_FFC0);
    nxt();
    chk("wrap_b1",     bus.mem_addr,      32'h0000_0000);
    chk("wrap_b1_idx", 32'(bus.beat_idx), 32'd1);
    nxt();
    check_burst(1'b0, 32'hFFFF_FFC0, 2, 2);
    bus.mem_ack = 1'b0;
    #1;
    for (int s = 0; s < 5; s++) begin
      chk("stall_req",  32'(bus.mem_req),   32'd1);
      chk("stall_addr", bus.mem_addr,       32'h0000_0080);
      chk("stall_idx",  32'(bus.beat_idx),  32'd3);
      chk("stall_rdwe", 32'(bus.rd_buf_we), 32'd0);
      if (s < 4) nxt();
    end
    bus.mem_ack = 1'b1;
    #1;
    check_burst(1'b0, 32'hFFFF_FFC0, 3, 7);
    check_quiet("wrap_end");

    // Reset during beat 4 with a WR pending: everything clears, nothing resumes.
    bus.request_read = 1'b1;
    bus.read_address = 32'h1000_0200;
    nxt();
    bus.request_read = 1'b0;
    nxt();
    bus.request_write = 1'b1;
    bus.write_address = 32'h5000_0000;
    check_burst(1'b0, 32'h1000_0200, 0, 0);
    bus.request_write = 1'b0;
    check_burst(1'b0, 32'h1000_0200, 1, 3);
    chk("mid_idx", 32'(bus.beat_idx), 32'd4);
    chk("mid_ovf", 32'(bus.req_overflow), 32'd1);
    rst_n = 1'b0;
    #1;
    check_quiet("mid_rst");
    chk("mid_rst_mkrq", 32'(bus.making_request), 32'd0);
    chk("mid_rst_ovf",  32'(bus.req_overflow),   32'd0);
    nxt();
    rst_n = 1'b1;
    nxt();
    nxt();
    check_quiet("after_rst");
    chk("after_rst_mkrq", 32'(bus.making_request), 32'd0);
    nxt();
    chk("after_rst_req2", 32'(bus.mem_req), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
